control_unit: RTL and testbench

// - Main decoder of the pipelined MIPS-style core, in the decode stage.
// - Maps 4-bit OpCode and 3-bit Function to ALU op, write enables and datapath selects S1..S9.
// - Outputs are registered: they are valid one cycle after the inputs and feed the ID/EX boundary.

---
 rtl/control_unit.sv | 126 ++++++++++++
 tb/tb_control_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Decode-stage main control unit: maps OpCode/Function to the ALU op, write
// enables and datapath selects, registered once so the bundle lands on the ID/EX boundary.
module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] OpCode,
    input  logic [2:0] Function,
    output logic [2:0] ALU,
    output logic       OUTLD,
    output logic       MWE,
    output logic       WE,
    output logic       S1,
    output logic       S2,
    output logic       S3,
    output logic       S4,
    output logic       S5,
    output logic       S6,
    output logic       S7,
    output logic       S8,
    output logic       S9
);

    typedef enum logic [3:0] {
        OP_RTYPE = 4'd0,
        OP_ADDI  = 4'd1,
        OP_ANDI  = 4'd2,
        OP_ORI   = 4'd3,
        OP_XORI  = 4'd4,
        OP_SLTI  = 4'd5,
        OP_LW    = 4'd6,
        OP_SW    = 4'd7,
        OP_BEQ   = 4'd8,
        OP_BNE   = 4'd9,
        OP_J     = 4'd10,
        OP_JAL   = 4'd11,
        OP_JR    = 4'd12,
        OP_OUT   = 4'd13
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_NOR = 3'b101,
        ALU_SLT = 3'b110,
        ALU_SLL = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic [2:0] alu;
        logic       outld;
        logic       mwe;
        logic       we;
        logic       s1;
        logic       s2;
        logic       s3;
        logic       s4;
        logic       s5;
        logic       s6;
        logic       s7;
        logic       s8;
        logic       s9;
    } ctrl_t;

    ctrl_t w_dec;
    ctrl_t r_ctrl;

    always_comb begin
        // NOTE: the all-zero default comes first so every field is assigned on
        // every path (no latch), and it doubles as the NOP bundle for 14/15.
        w_dec = '0;
        case (opcode_e'(OpCode))
            OP_RTYPE: begin w_dec.alu = Function; w_dec.we = 1'b1; w_dec.s1 = 1'b1; end
            OP_ADDI:  begin w_dec.alu = ALU_ADD; w_dec.we = 1'b1; w_dec.s2 = 1'b1; w_dec.s4 = 1'b1; end
            OP_ANDI:  begin w_dec.alu = ALU_AND; w_dec.we = 1'b1; w_dec.s2 = 1'b1; end
            OP_ORI:   begin w_dec.alu = ALU_OR;  w_dec.we = 1'b1; w_dec.s2 = 1'b1; end
            OP_XORI:  begin w_dec.alu = ALU_XOR; w_dec.we = 1'b1; w_dec.s2 = 1'b1; end
            OP_SLTI:  begin w_dec.alu = ALU_SLT; w_dec.we = 1'b1; w_dec.s2 = 1'b1; w_dec.s4 = 1'b1; end
            OP_LW: begin
                w_dec.alu = ALU_ADD;
                w_dec.we  = 1'b1;
                w_dec.s2  = 1'b1;
                w_dec.s3  = 1'b1;
                w_dec.s4  = 1'b1;
            end
            OP_SW:    begin w_dec.alu = ALU_ADD; w_dec.mwe = 1'b1; w_dec.s2 = 1'b1; w_dec.s4 = 1'b1; end
            OP_BEQ:   begin w_dec.alu = ALU_SUB; w_dec.s4 = 1'b1; w_dec.s5 = 1'b1; end
            OP_BNE: begin
                w_dec.alu = ALU_SUB;
                w_dec.s4  = 1'b1;
                w_dec.s5  = 1'b1;
                w_dec.s9  = 1'b1;
            end
            OP_J:     w_dec.s6 = 1'b1;
            // Link writes PC+1 to r7, so the RF write enable rides along with S8.
            OP_JAL:   begin w_dec.s6 = 1'b1; w_dec.s8 = 1'b1; w_dec.we = 1'b1; end
            OP_JR:    w_dec.s7 = 1'b1;
            OP_OUT:   begin w_dec.outld = 1'b1; w_dec.alu = ALU_ADD; end
            default:  w_dec = '0;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments; reset is sampled
    // on the clock edge and wins over any decode.
    always_ff @(posedge clk) begin
        if (rst) r_ctrl <= '0;
        else     r_ctrl <= w_dec;
    end

    assign ALU   = r_ctrl.alu;
    assign OUTLD = r_ctrl.outld;
    assign MWE   = r_ctrl.mwe;
    assign WE    = r_ctrl.we;
    assign S1    = r_ctrl.s1;
    assign S2    = r_ctrl.s2;
    assign S3    = r_ctrl.s3;
    assign S4    = r_ctrl.s4;
    assign S5    = r_ctrl.s5;
    assign S6    = r_ctrl.s6;
    assign S7    = r_ctrl.s7;
    assign S8    = r_ctrl.s8;
    assign S9    = r_ctrl.s9;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus an exhaustive
// sweep and random stream, checked against a set-membership model of the decode table.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] OpCode;
    logic [2:0] Function;
    logic [2:0] ALU;
    logic       OUTLD, MWE, WE, S1, S2, S3, S4, S5, S6, S7, S8, S9;

    int checks = 0;
    int errors = 0;

    // ALU op per opcode for the non-R-type instructions (index 0 is overridden by Function).
    int alu_tab [16] = '{0, 0, 2, 3, 4, 6, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};

    control_unit dut (
        .clk(clk), .rst(rst), .OpCode(OpCode), .Function(Function),
        .ALU(ALU), .OUTLD(OUTLD), .MWE(MWE), .WE(WE),
        .S1(S1), .S2(S2), .S3(S3), .S4(S4), .S5(S5),
        .S6(S6), .S7(S7), .S8(S8), .S9(S9)
    );

    always #5 clk = ~clk;

    // Bundle order: {ALU[2:0], OUTLD, MWE, WE, S1..S9}
    function automatic logic [14:0] model(int op, int fn, bit r);
        logic [2:0] alu;
        if (r) return '0;
        alu = (op == 0) ? 3'(fn) : 3'(alu_tab[op]);
        return {alu,
                op == 13,                          // OUTLD
                op == 7,                           // MWE
                (op inside {[0:6]}) || op == 11,   // WE
                op == 0,                           // S1 rd
                op inside {[1:7]},                 // S2 immediate
                op == 6,                           // S3 memory data
                op inside {1, 5, 6, 7, 8, 9},      // S4 sign extend
                op inside {8, 9},                  // S5 branch
                op inside {10, 11},                // S6 jump
                op == 12,                          // S7 jr
                op == 11,                          // S8 link
                op == 9};                          // S9 bne
    endfunction

    function automatic logic [14:0] observed();
        return {ALU, OUTLD, MWE, WE, S1, S2, S3, S4, S5, S6, S7, S8, S9};
    endfunction

    // Apply one cycle of inputs mid-low-phase, then settle just after the edge.
    task automatic drive(input int op, input int fn, input bit r);
        @(negedge clk);
        OpCode   = 4'(op);
        Function = 3'(fn);
        rst      = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1'b1);
            checks++;
            if (observed() !== 15'd0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %b expected %b", i, observed(), 15'd0);
            end
        end
        drive(0, 0, 1'b0);
        checks++;
        if (observed() !== model(0, 0, 1'b0)) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", observed(), model(0, 0, 1'b0));
        end
    endtask

    task automatic test_rtype();
        for (int f = 0; f < 8; f++) begin
            drive(0, f, 1'b0);
            checks++;
            if (observed() !== model(0, f, 1'b0) || ALU !== 3'(f)) begin
                errors++;
                $display("FAIL rtype fn=%0d: got %b expected %b", f, observed(), model(0, f, 1'b0));
            end
        end
    endtask

    task automatic test_directed();
        int ops [4] = '{7, 6, 9, 11};
        foreach (ops[i]) begin
            drive(ops[i], 1, 1'b0);
            checks++;
            if (observed() !== model(ops[i], 1, 1'b0)) begin
                errors++;
                $display("FAIL directed op=%0d: got %b expected %b", ops[i], observed(),
                         model(ops[i], 1, 1'b0));
            end
        end
    endtask

    task automatic test_reset_midstream();
        bit rs [3] = '{1'b0, 1'b1, 1'b0};
        foreach (rs[i]) begin
            drive(6, 3, rs[i]);
            checks++;
            if (observed() !== model(6, 3, rs[i])) begin
                errors++;
                $display("FAIL reset_mid step=%0d: got %b expected %b", i, observed(),
                         model(6, 3, rs[i]));
            end
        end
    endtask

    task automatic test_reserved();
        for (int op = 14; op < 16; op++) begin
            drive(op, $urandom_range(7), 1'b0);
            checks++;
            if (observed() !== 15'd0) begin
                errors++;
                $display("FAIL reserved op=%0d: got %b expected %b", op, observed(), 15'd0);
            end
        end
    endtask

    task automatic test_sweep();
        for (int op = 0; op < 16; op++) begin
            for (int f = 0; f < 8; f++) begin
                drive(op, f, 1'b0);
                checks++;
                if (observed() !== model(op, f, 1'b0)) begin
                    errors++;
                    $display("FAIL sweep op=%0d fn=%0d: got %b expected %b", op, f, observed(),
                             model(op, f, 1'b0));
                end
                checks++;
                if (int'(S5) + int'(S6) + int'(S7) > 1 || (MWE && WE)) begin
                    errors++;
                    $display("FAIL exclusive op=%0d: got S5S6S7=%b%b%b MWE/WE=%b%b required one-hot-or-zero, not both",
                             op, S5, S6, S7, MWE, WE);
                end
            end
        end
    endtask

    // Random back-to-back stream with occasional reset pulses.
    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            int op = $urandom_range(15);
            int f  = $urandom_range(7);
            bit r  = ($urandom_range(15) == 0);
            drive(op, f, r);
            checks++;
            if (observed() !== model(op, f, r)) begin
                errors++;
                $display("FAIL random[%0d] op=%0d fn=%0d rst=%0b: got %b expected %b", i, op, f, r,
                         observed(), model(op, f, r));
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        OpCode   = '0;
        Function = '0;
        test_reset();
        test_rtype();
        test_directed();
        test_reset_midstream();
        test_reserved();
        test_sweep();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
